// File: rtl/sensor_dir_detector.sv
// sensor_dir_detector
//   Tracks the order in which two beam-break sensors (A outer, B inner) block
//   and clear. Emits one-cycle pulses for each completed entry (inc) and each
//   completed exit (dec). Reversals and partial passes produce no pulse.
//   Illegal two-bit pattern jumps produce a one-cycle err pulse.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive mismatching cycles before a filtered bit
//                     follows its synchronized bit (1..255). It is only used
//                     when SENSOR_DEBOUNCE_EN is defined.
//
// Ports
//   clk   : clock
//   reset : synchronous active-high reset
//   a     : outer sensor, asynchronous, 1 = blocked
//   b     : inner sensor, asynchronous, 1 = blocked
//   inc   : registered one-cycle pulse per completed entry
//   dec   : registered one-cycle pulse per completed exit
//   err   : registered one-cycle pulse per illegal transition
//   busy  : registered, high while the FSM is not in IDLE
//
// Configuration macro
//   SENSOR_DEBOUNCE_EN : when defined, each sensor bit gets an 8-bit mismatch
//                        counter. When undefined, the filter is a pass-through.

module sensor_dir_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic inc,
  output logic dec,
  output logic err,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_AB,
    ENT_B,
    EXT_B,
    EXT_AB,
    EXT_A,
    WAIT_CLR
  } state_t;

  // Bit 1 carries sensor A and bit 0 carries sensor B, so the pattern is {a, b}.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;

  state_t state;
  state_t state_nxt;
  logic   inc_nxt;
  logic   dec_nxt;
  logic   err_nxt;

  // 2-flop synchronizer for both sensors.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [2];

  // Per-bit mismatch counter. The filtered bit flips on the last mismatching edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt   <= 2'b00;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (cnt[i] == CNT_LAST) begin
            filt[i] <= sync2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      inc   <= 1'b0;
      dec   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      inc   <= inc_nxt;
      dec   <= dec_nxt;
      err   <= err_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state logic. A two-bit pattern change from any tracked step is illegal.
  always_comb begin
    state_nxt = state;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        case (filt)
          2'b10:   state_nxt = ENT_A;
          2'b01:   state_nxt = EXT_B;
          2'b11:   begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
          default: state_nxt = IDLE;
        endcase
      end
      ENT_A: begin
        case (filt)
          2'b11:   state_nxt = ENT_AB;
          2'b10:   state_nxt = ENT_A;
          2'b00:   state_nxt = IDLE;
          default: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
        endcase
      end
      ENT_AB: begin
        case (filt)
          2'b01:   state_nxt = ENT_B;
          2'b11:   state_nxt = ENT_AB;
          2'b10:   state_nxt = ENT_A;
          default: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
        endcase
      end
      ENT_B: begin
        case (filt)
          2'b00:   begin state_nxt = IDLE; inc_nxt = 1'b1; end
          2'b01:   state_nxt = ENT_B;
          2'b11:   state_nxt = ENT_AB;
          default: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
        endcase
      end
      EXT_B: begin
        case (filt)
          2'b11:   state_nxt = EXT_AB;
          2'b01:   state_nxt = EXT_B;
          2'b00:   state_nxt = IDLE;
          default: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
        endcase
      end
      EXT_AB: begin
        case (filt)
          2'b10:   state_nxt = EXT_A;
          2'b11:   state_nxt = EXT_AB;
          2'b01:   state_nxt = EXT_B;
          default: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
        endcase
      end
      EXT_A: begin
        case (filt)
          2'b00:   begin state_nxt = IDLE; dec_nxt = 1'b1; end
          2'b10:   state_nxt = EXT_A;
          2'b11:   state_nxt = EXT_AB;
          default: begin state_nxt = WAIT_CLR; err_nxt = 1'b1; end
        endcase
      end
      WAIT_CLR: begin
        if (filt == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sensor_dir_detector.sv
// tb_sensor_dir_detector
//   Directed, table-driven bench for sensor_dir_detector plus hand-written
//   sequences for the multi-cycle corner cases (11->00 jump, reset mid-entry,
//   glitch rejection when SENSOR_DEBOUNCE_EN is defined).
//   Expected outputs are packed as {inc, dec, err, busy}.

module tb_sensor_dir_detector;

  localparam int unsigned DEB = 4;
`ifdef SENSOR_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic a;
  logic b;
  logic inc;
  logic dec;
  logic err;
  logic busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic prev_busy;

  typedef struct packed {
    logic       a;
    logic       b;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  sensor_dir_detector #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .inc  (inc),
    .dec  (dec),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: inc/dec/err/busy got %b expected %b", name, idx, act, exp);
  endtask

  task automatic add(input logic va, input logic vb, input logic [3:0] exp);
    vec_t v;
    v.a = va; v.b = vb; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Called at a negedge: drive the pattern, confirm outputs hold steady until
  // the transition lands LAT edges later, then check the landing cycle.
  task automatic apply(input logic va, input logic vb, input logic [3:0] exp, input int idx);
    a = va;
    b = vb;
    for (int i = 0; i <= LAT; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < LAT) chk("hold", idx, {inc, dec, err, busy}, {3'b000, prev_busy});
      else         chk("vec", idx, {inc, dec, err, busy}, exp);
    end
    prev_busy = exp[0];
  endtask

  initial begin
    int glitch_busy;
    int glitch_pulse;

    a = 1'b0;
    b = 1'b0;
    reset = 1'b1;
    prev_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 0, {inc, dec, err, busy}, 4'b0000);
    reset = 1'b0;

    // Full entry.
    add(1, 0, 4'b0001); add(1, 1, 4'b0001); add(0, 1, 4'b0001); add(0, 0, 4'b1000);
    // Full exit.
    add(0, 1, 4'b0001); add(1, 1, 4'b0001); add(1, 0, 4'b0001); add(0, 0, 4'b0100);
    // Entry reversal back out of A.
    add(1, 0, 4'b0001); add(1, 1, 4'b0001); add(1, 0, 4'b0001); add(0, 0, 4'b0000);
    // Illegal jump from IDLE, no further err while waiting.
    add(1, 1, 4'b0011); add(0, 1, 4'b0001); add(0, 0, 4'b0000);
    // Reversal inside entry chain still completes.
    add(1, 0, 4'b0001); add(1, 1, 4'b0001); add(0, 1, 4'b0001);
    add(1, 1, 4'b0001); add(0, 1, 4'b0001); add(0, 0, 4'b1000);
    // 10 -> 01 jump in ENT_A.
    add(1, 0, 4'b0001); add(0, 1, 4'b0011); add(0, 0, 4'b0000);
    // Exit walk-away.
    add(0, 1, 4'b0001); add(0, 0, 4'b0000);
    // Exit reversal then completion.
    add(0, 1, 4'b0001); add(1, 1, 4'b0001); add(1, 0, 4'b0001);
    add(1, 1, 4'b0001); add(1, 0, 4'b0001); add(0, 0, 4'b0100);
    // Back-to-back entries.
    add(1, 0, 4'b0001); add(1, 1, 4'b0001); add(0, 1, 4'b0001); add(0, 0, 4'b1000);
    add(1, 0, 4'b0001); add(1, 1, 4'b0001); add(0, 1, 4'b0001); add(0, 0, 4'b1000);
    // 01 -> 10 jump in EXT_B.
    add(0, 1, 4'b0001); add(1, 0, 4'b0011); add(0, 0, 4'b0000);

    foreach (tbl[i]) apply(tbl[i].a, tbl[i].b, tbl[i].exp, i);

    // 11 -> 00 in ENT_AB: err, then WAIT_CLR leaves on the following edge.
    apply(1, 0, 4'b0001, 100);
    apply(1, 1, 4'b0001, 101);
    apply(0, 0, 4'b0011, 102);
    @(posedge clk);
    @(negedge clk);
    chk("wait_clr_exit", 103, {inc, dec, err, busy}, 4'b0000);
    prev_busy = 1'b0;

    // Reset while in ENT_AB, sensors move on to 01 during reset.
    apply(1, 0, 4'b0001, 200);
    apply(1, 1, 4'b0001, 201);
    reset = 1'b1;
    a = 1'b0;
    b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid", 202, {inc, dec, err, busy}, 4'b0000);
    prev_busy = 1'b0;
    apply(0, 1, 4'b0001, 203);
    apply(0, 0, 4'b0000, 204);

`ifdef SENSOR_DEBOUNCE_EN
    // 3-cycle glitch on a is filtered out entirely.
    glitch_busy = 0;
    glitch_pulse = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) a = 1'b1;
      if (i == 3) a = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (busy) glitch_busy++;
      if (inc || dec || err) glitch_pulse++;
    end
    chk("glitch3_busy", 300, 4'(glitch_busy), 4'd0);
    chk("glitch3_pulse", 301, 4'(glitch_pulse), 4'd0);

    // 6-cycle pulse reaches ENT_A for 6 cycles, then walks away silently.
    glitch_busy = 0;
    glitch_pulse = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) a = 1'b1;
      if (i == 6) a = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (busy) glitch_busy++;
      if (inc || dec || err) glitch_pulse++;
    end
    chk("pulse6_busy", 302, 4'(glitch_busy), 4'd6);
    chk("pulse6_pulse", 303, 4'(glitch_pulse), 4'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sensor_dir_detector.md
# sensor_dir_detector

Upstream stage of the 32-bit up/down occupancy counter. It samples two asynchronous beam-break sensors, A (outer) and B (inner), and tracks the order in which they block and clear. It emits single-cycle `inc` pulses for complete entries and `dec` pulses for complete exits, wired directly to the counter's `inc`/`dec` inputs. Reversals, partial passes and illegal jumps produce no count pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a synchronized sensor bit is accepted; legal range 1..255.
- `clk`  input  1: the block's only clock.
- `reset`  input  1: synchronous, active-high reset; one clock, synchronous active-high reset.
- `a`  input  1: outer sensor, asynchronous, 1 = blocked.
- `b`  input  1: inner sensor, asynchronous, 1 = blocked.
- `inc`  output  1: one-cycle pulse on each completed entry.
- `dec`  output  1: one-cycle pulse on each completed exit.
- `err`  output  1: one-cycle pulse on each illegal pattern transition.
- `busy`  output  1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer.** Each of `a` and `b` passes through a 2-flop synchronizer, giving synchronized bits `sa` and `sb`.
- **Filter.** Produces the filtered pattern `p = {fa, fb}`; behaviour is set by the macro below. Each bit is filtered independently.
- **FSM states.** IDLE, ENT_A (10), ENT_AB (11), ENT_B (01), EXT_B (01), EXT_AB (11), EXT_A (10), WAIT_CLR.
- **IDLE:**
  - p=10 → ENT_A.
  - p=01 → EXT_B.
  - p=00 → stay.
  - p=11 → WAIT_CLR, `err`.
- **Entry chain (ENT_A → ENT_AB → ENT_B):**
  - Pattern equal to the next step's pattern advances one step.
  - Pattern equal to the current step's pattern holds.
  - Pattern equal to the previous step's pattern steps back one (a reversal is allowed).
  - p=00 in ENT_B → IDLE with `inc`.
  - p=00 in ENT_A → IDLE with no pulse (walk-away).
  - Any other pattern → WAIT_CLR with `err`.
- **Exit chain (EXT_B → EXT_AB → EXT_A):** symmetric to the entry chain. p=00 in EXT_A → IDLE with `dec`; p=00 in EXT_B → IDLE with no pulse.
- **Illegal transitions** are a two-bit change in one step, e.g. 10→01, 00→11, or 11→00.
- **WAIT_CLR:** stays until p=00, then → IDLE with no pulse. No `err` is re-issued while waiting.
- **Outputs:**
  - `inc`, `dec` and `err` are registered and never asserted simultaneously.
  - `busy` is registered and equals (state ≠ IDLE).
- **Reset:**
  - Sync flops, filtered bits and debounce counters clear to 0.
  - State goes to IDLE.
  - `inc`=`dec`=`err`=`busy`=0.
  - Reset mid-sequence discards the sequence with no pulse. If sensors are still blocked afterwards, the pattern re-enters from IDLE as a fresh sequence.

## Timing
- Without the debounce macro, a sensor change that is set up before edge k produces FSM transition and output register update at edge k+2.
  - `inc`/`dec`/`err` are therefore high for exactly the cycle after edge k+2.
- With the debounce macro, the same change produces its output at edge k+2+DEBOUNCE_CYCLES.
- `busy` follows the state with the same latency.
- Back-to-back entries: a new sequence may start in the same edge that returns to IDLE only if p≠00. Because the pattern must pass through 00 to complete, the minimum spacing is one idle cycle with p=00.
- Pulses are never stretched or merged. Each completed sequence yields exactly one pulse.

## Configuration
- Macro `SENSOR_DEBOUNCE_EN` selects the filter behaviour.
- **Defined:**
  - Each bit has an 8-bit mismatch counter.
  - On every edge where the synchronized bit differs from the filtered bit, the counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive mismatching edge, the filtered bit takes the synchronized value and the counter clears.
  - Any matching edge clears the counter.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- **Undefined:** the filtered bit equals the synchronized bit (`fa`=`sa`, `fb`=`sb`), no counters are instantiated, and `DEBOUNCE_CYCLES` is unused.

## Test plan
- **Full entry, no debounce:** a,b steps 00→10→11→01→00, each held 3 cycles → exactly one `inc` pulse 2 edges after the final 00; `dec`=`err`=0; `busy` high from 2 edges after `a` rises until `inc`.
- **Full exit, SENSOR_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:** 00→01→11→10→00, each held 8 cycles → one `dec` pulse 6 edges after the final 00; no `inc`.
- **Reversal:** 00→10→11→10→00 → returns to IDLE with no `inc`/`dec`/`err`; `busy` then drops.
- **Illegal jump:** from IDLE apply 11 directly → `err` for one cycle, state WAIT_CLR, `busy`=1. Then 01, then 00 → no further `err`, `busy`=0, no count pulse.
- **Glitch rejection (debounce on, 4):** 3-cycle pulse on `a` → no state change, `busy` stays 0. A 6-cycle pulse → ENT_A, then 00 → IDLE with no pulse.
- **Reset mid-entry:** assert `reset` for 1 cycle while in ENT_AB → next cycle all outputs 0 and `busy`=0. Continuing 01→00 afterwards yields no `inc`, because the sequence re-enters at EXT_B and returns to IDLE without a pulse.
